// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions: the set-associative instruction cache frame,
// its controller states and the fetch-address field layout.
package cpu_types_pkg;

  // Default geometry of the set-associative instruction cache
  localparam int ICACHE_WORD_W    = 32;
  localparam int ICACHE_SETS      = 8;
  localparam int ICACHE_WAYS      = 2;
  localparam int ICACHE_BLK_WORDS = 2;
  localparam int ICACHE_IDX_W     = $clog2(ICACHE_SETS);
  localparam int ICACHE_WOFF_W    = $clog2(ICACHE_BLK_WORDS);
  localparam int ICACHE_TAG_W     = ICACHE_WORD_W - 2 - ICACHE_WOFF_W - ICACHE_IDX_W;

  // Controller states: serve hits, stream a block in, commit it to the array
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } icache_state_t;

  // Byte address split into tag / set index / word-in-block / byte
  typedef struct packed {
    logic [ICACHE_TAG_W-1:0]  tag;
    logic [ICACHE_IDX_W-1:0]  idx;
    logic [ICACHE_WOFF_W-1:0] woff;
    logic [1:0]               bo;
  } icache_addr_t;

  // One cache line (frame) as held in a set/way
  typedef struct packed {
    logic                                          valid;
    logic [ICACHE_TAG_W-1:0]                       tag;
    logic [ICACHE_BLK_WORDS-1:0][ICACHE_WORD_W-1:0] data;
  } icache_frame_t;

  // log2 that never returns zero, for sizing selectors of 1-entry ranges
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/icache_sa_lookup.sv
// Combinational tag compare across all ways of one set.
// Returns whether any valid way matches and which way it is.
module icache_sa_lookup #(
  parameter int TAG_W  = 26,
  parameter int WAYS   = 2,
  parameter int WAY_SW = 1
) (
  input  logic [TAG_W-1:0]  tag,
  input  logic [TAG_W-1:0]  way_tag [WAYS],
  input  logic [WAYS-1:0]   way_valid,
  output logic              hit,
  output logic [WAY_SW-1:0] way
);

  // Scan every way; tags are unique within a set so at most one matches
  always_comb begin
    // NOTE: combinational outputs get a default before the loop so no path
    // leaves them unassigned (no latch), and use blocking '=' throughout.
    hit = 1'b0;
    way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_valid[w] && (way_tag[w] == tag)) begin
        hit = 1'b1;
        way = WAY_SW'(w);
      end
    end
  end

endmodule

// File: rtl/icache_sa.sv
// Set-associative, multi-word-block instruction cache between fetch and the
// memory arbiter. Hits are served combinationally; a miss streams the whole
// block in through the arbiter, then commits it to a round-robin victim way.
// Supports a global flush and counts misses.
module icache_sa
  import cpu_types_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int SETS      = 8,
  parameter int WAYS      = 2,
  parameter int BLK_WORDS = 2,
  parameter int CNT_W     = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              imemREN,
  input  logic [WORD_W-1:0] imemaddr,
  output logic              ihit,
  output logic [WORD_W-1:0] imemload,
  input  logic              flush,
  output logic              iREN,
  output logic [WORD_W-1:0] iaddr,
  input  logic              iwait,
  input  logic [WORD_W-1:0] iload,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int IDX_W   = $clog2(SETS);
  localparam int WOFF_W  = $clog2(BLK_WORDS);
  localparam int TAG_W   = WORD_W - 2 - WOFF_W - IDX_W;
  localparam int WOFF_SW = clog2_min1(BLK_WORDS);
  localparam int WAY_SW  = clog2_min1(WAYS);

  // Fetch address fields
  logic [TAG_W-1:0]   req_tag;
  logic [IDX_W-1:0]   req_idx;
  logic [WOFF_SW-1:0] req_off;
  logic               unused_byte_bits;

  assign req_tag          = imemaddr[WORD_W-1 -: TAG_W];
  assign req_idx          = imemaddr[2+WOFF_W +: IDX_W];
  assign unused_byte_bits = ^imemaddr[1:0];

  generate
    if (WOFF_W == 0) begin : g_off_single
      assign req_off = '0;
    end else begin : g_off_multi
      assign req_off = imemaddr[2 +: WOFF_W];
    end
  endgenerate

  // Line storage: valid and round-robin pointers are control state, tag and
  // data arrays are plain memory
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAY_SW-1:0] rr_q    [SETS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [WORD_W-1:0] data_q  [SETS][WAYS][BLK_WORDS];

  // Miss context captured when a fill starts
  icache_state_t      state_q, state_d;
  logic [TAG_W-1:0]   miss_tag_q;
  logic [IDX_W-1:0]   miss_idx_q;
  logic [WAY_SW-1:0]  victim_q;
  logic [WOFF_SW-1:0] fill_cnt_q;
  logic [WORD_W-1:0]  line_buf_q [BLK_WORDS];
  logic [CNT_W-1:0]   miss_cnt_q;
  logic [WORD_W-1:0]  fill_addr;

  // Lookup results for the indexed set
  logic [TAG_W-1:0]  set_tags [WAYS];
  logic              lookup_hit;
  logic [WAY_SW-1:0] hit_way;

  // Control events
  logic miss_start;
  logic beat_ok;
  logic last_beat;
  logic commit;

  // Present the tags of the indexed set to the comparator
  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      set_tags[w] = tag_q[req_idx][w];
    end
  end

  icache_sa_lookup #(
    .TAG_W  (TAG_W),
    .WAYS   (WAYS),
    .WAY_SW (WAY_SW)
  ) u_lookup (
    .tag       (req_tag),
    .way_tag   (set_tags),
    .way_valid (valid_q[req_idx]),
    .hit       (lookup_hit),
    .way       (hit_way)
  );

  assign miss_start = (state_q == IDLE) && imemREN && !lookup_hit && !flush;
  assign beat_ok    = (state_q == FILL) && !iwait && !flush;
  assign last_beat  = beat_ok && (fill_cnt_q == WOFF_SW'(BLK_WORDS - 1));
  assign commit     = (state_q == WRITE) && !flush;

  // Word address of the current beat: block base plus word counter
  generate
    if (WOFF_W == 0) begin : g_addr_single
      assign fill_addr = {miss_tag_q, miss_idx_q, 2'b00};
    end else begin : g_addr_multi
      assign fill_addr = {miss_tag_q, miss_idx_q, fill_cnt_q, 2'b00};
    end
  endgenerate

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    // NOTE: registered state is always written with non-blocking '<=' so
    // every flop samples values from before the clock edge.
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: miss starts a fill, flush aborts anything back to IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (miss_start) state_d = FILL;
      FILL: begin
        if (flush)          state_d = IDLE;
        else if (last_beat) state_d = WRITE;
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: hits only while idle, arbiter request only while filling
  always_comb begin
    ihit     = 1'b0;
    imemload = '0;
    iREN     = 1'b0;
    iaddr    = '0;
    if ((state_q == IDLE) && imemREN && !flush && lookup_hit) begin
      ihit     = 1'b1;
      imemload = data_q[req_idx][hit_way][req_off];
    end
    if (state_q == FILL) begin
      iREN  = 1'b1;
      iaddr = fill_addr;
    end
  end

  // Miss context, beat counter and miss counter
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      miss_tag_q <= '0;
      miss_idx_q <= '0;
      victim_q   <= '0;
      fill_cnt_q <= '0;
      miss_cnt_q <= '0;
    end else if (miss_start) begin
      miss_tag_q <= req_tag;
      miss_idx_q <= req_idx;
      victim_q   <= rr_q[req_idx];
      fill_cnt_q <= '0;
      miss_cnt_q <= miss_cnt_q + 1'b1;
    end else if (beat_ok) begin
      fill_cnt_q <= fill_cnt_q + 1'b1;
    end
  end

  // Collect accepted beats into the line buffer
  always_ff @(posedge CLK) begin
    // NOTE: buffer and tag/data arrays carry no reset; valid bits alone say
    // whether their contents mean anything.
    if (beat_ok) line_buf_q[fill_cnt_q] <= iload;
  end

  // Valid bits and round-robin pointers: cleared by flush, updated on commit
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else if (flush) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else if (commit) begin
      valid_q[miss_idx_q][victim_q] <= 1'b1;
      rr_q[miss_idx_q]              <= (WAYS == 1) ? '0 : victim_q + 1'b1;
    end
  end

  // Commit the buffered block and its tag into the victim way
  always_ff @(posedge CLK) begin
    if (commit) begin
      tag_q[miss_idx_q][victim_q] <= miss_tag_q;
      for (int k = 0; k < BLK_WORDS; k++) begin
        data_q[miss_idx_q][victim_q][k] <= line_buf_q[k];
      end
    end
  end

  assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_icache_sa.sv
// Directed testbench for icache_sa with default parameters.
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_icache_sa;

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        flush;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [15:0] miss_cnt;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  icache_sa dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .ihit     (ihit),
    .imemload (imemload),
    .flush    (flush),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .miss_cnt (miss_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Backing memory: two known words at 0x100/0x104, address-tagged elsewhere
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h100) return 32'h0000_00A0;
    if (a == 32'h104) return 32'h0000_00A1;
    return 32'hD000_0000 | a;
  endfunction

  assign iload = mem_word(iaddr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for the fetch in progress to hit
  task automatic wait_hit(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge CLK); #1;
      n++;
    end while (!ihit && n < 40);
    check({tag, " hit after fill"}, {31'd0, ihit}, 32'd1);
  endtask

  // Request an address that must miss, then wait until it hits
  task automatic fetch_miss(input logic [31:0] a, input string tag);
    @(negedge CLK);
    imemREN  = 1'b1;
    imemaddr = a;
    #1;
    check({tag, " first lookup misses"}, {31'd0, ihit}, 32'd0);
    wait_hit(tag);
  endtask

  task automatic reset_dut();
    @(negedge CLK);
    nRST    = 1'b0;
    imemREN = 1'b0;
    flush   = 1'b0;
    iwait   = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    nRST     = 1'b0;
    imemREN  = 1'b0;
    imemaddr = '0;
    flush    = 1'b0;
    iwait    = 1'b0;

    // Reset state
    @(negedge CLK); #1;
    check("rst ihit",     {31'd0, ihit}, 32'd0);
    check("rst imemload", imemload,      32'd0);
    check("rst iREN",     {31'd0, iREN}, 32'd0);
    check("rst iaddr",    iaddr,         32'd0);
    check("rst miss_cnt", {16'd0, miss_cnt}, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;

    // 1: basic miss, two-beat fill, then hits on both words
    @(negedge CLK);
    imemREN  = 1'b1;
    imemaddr = 32'h100;
    #1;
    check("t1 idle ihit", {31'd0, ihit}, 32'd0);
    check("t1 idle iREN", {31'd0, iREN}, 32'd0);
    @(negedge CLK); #1;
    check("t1 beat0 iREN",  {31'd0, iREN}, 32'd1);
    check("t1 beat0 iaddr", iaddr, 32'h100);
    @(negedge CLK); #1;
    check("t1 beat1 iREN",  {31'd0, iREN}, 32'd1);
    check("t1 beat1 iaddr", iaddr, 32'h104);
    @(negedge CLK); #1;
    check("t1 write iREN", {31'd0, iREN}, 32'd0);
    check("t1 write ihit", {31'd0, ihit}, 32'd0);
    @(negedge CLK); #1;
    check("t1 hit ihit",     {31'd0, ihit}, 32'd1);
    check("t1 hit load0",    imemload, 32'h0000_00A0);
    check("t1 miss_cnt",     {16'd0, miss_cnt}, 32'd1);
    @(negedge CLK);
    imemaddr = 32'h104;
    #1;
    check("t1 hit word1",  {31'd0, ihit}, 32'd1);
    check("t1 load word1", imemload, 32'h0000_00A1);
    @(negedge CLK);
    imemREN = 1'b0;
    #1;
    check("t1 no req ihit", {31'd0, ihit}, 32'd0);
    check("t1 no req load", imemload, 32'd0);

    // 2: three blocks into one 2-way set; round robin evicts the oldest
    reset_dut();
    fetch_miss(32'h000, "t2 0x000");
    check("t2 load 0x000", imemload, 32'hD000_0000);
    fetch_miss(32'h040, "t2 0x040");
    check("t2 load 0x040", imemload, 32'hD000_0040);
    fetch_miss(32'h080, "t2 0x080");
    check("t2 load 0x080", imemload, 32'hD000_0080);
    @(negedge CLK);
    imemaddr = 32'h040;
    #1;
    check("t2 0x040 still hits", {31'd0, ihit}, 32'd1);
    check("t2 0x040 data",       imemload, 32'hD000_0040);
    @(negedge CLK);
    imemaddr = 32'h080;
    #1;
    check("t2 0x080 hits", {31'd0, ihit}, 32'd1);
    fetch_miss(32'h000, "t2 0x000 evicted");
    check("t2 refetch data", imemload, 32'hD000_0000);
    check("t2 miss_cnt",     {16'd0, miss_cnt}, 32'd4);

    // 3: every beat stalled 5 cycles by iwait
    @(negedge CLK);
    iwait    = 1'b1;
    imemaddr = 32'h400;
    #1;
    check("t3 idle ihit", {31'd0, ihit}, 32'd0);
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < 5; k++) begin
        @(negedge CLK);
        iwait = 1'b1;
        #1;
        check("t3 stall iaddr", iaddr, 32'h400 + 32'(4 * b));
        check("t3 stall iREN",  {31'd0, iREN}, 32'd1);
        check("t3 stall ihit",  {31'd0, ihit}, 32'd0);
      end
      @(negedge CLK);
      iwait = 1'b0;
      #1;
      check("t3 accept iaddr", iaddr, 32'h400 + 32'(4 * b));
    end
    @(negedge CLK); #1;
    check("t3 write ihit", {31'd0, ihit}, 32'd0);
    @(negedge CLK); #1;
    check("t3 hit",      {31'd0, ihit}, 32'd1);
    check("t3 data",     imemload, 32'hD000_0400);
    check("t3 miss_cnt", {16'd0, miss_cnt}, 32'd5);

    // 4: flush on the second fill cycle aborts and invalidates everything
    reset_dut();
    fetch_miss(32'h100, "t4 0x100");
    check("t4 load 0x100", imemload, 32'h0000_00A0);
    @(negedge CLK);
    imemaddr = 32'h200;
    #1;
    check("t4 idle ihit", {31'd0, ihit}, 32'd0);
    @(negedge CLK); #1;
    check("t4 fill1 iaddr", iaddr, 32'h200);
    @(negedge CLK);
    flush = 1'b1;
    #1;
    check("t4 flush ihit", {31'd0, ihit}, 32'd0);
    check("t4 flush iREN", {31'd0, iREN}, 32'd1);
    @(negedge CLK);
    flush = 1'b0;
    #1;
    check("t4 after flush iREN", {31'd0, iREN}, 32'd0);
    check("t4 after flush ihit", {31'd0, ihit}, 32'd0);
    check("t4 after flush cnt",  {16'd0, miss_cnt}, 32'd2);
    wait_hit("t4 0x200 refill");
    check("t4 0x200 data", imemload, 32'hD000_0200);
    check("t4 0x200 cnt",  {16'd0, miss_cnt}, 32'd3);
    fetch_miss(32'h100, "t4 0x100 flushed");
    check("t4 0x100 data", imemload, 32'h0000_00A0);
    check("t4 final cnt",  {16'd0, miss_cnt}, 32'd4);

    // 5: fetch address moves to a cached block during a fill
    @(negedge CLK);
    imemaddr = 32'h300;
    #1;
    check("t5 idle ihit", {31'd0, ihit}, 32'd0);
    @(negedge CLK);
    imemaddr = 32'h100;
    #1;
    check("t5 fill1 ihit",  {31'd0, ihit}, 32'd0);
    check("t5 fill1 iaddr", iaddr, 32'h300);
    @(negedge CLK); #1;
    check("t5 fill2 ihit",  {31'd0, ihit}, 32'd0);
    check("t5 fill2 iaddr", iaddr, 32'h304);
    @(negedge CLK); #1;
    check("t5 write ihit", {31'd0, ihit}, 32'd0);
    @(negedge CLK); #1;
    check("t5 0x100 hit",  {31'd0, ihit}, 32'd1);
    check("t5 0x100 data", imemload, 32'h0000_00A0);
    @(negedge CLK);
    imemaddr = 32'h300;
    #1;
    check("t5 0x300 hit",  {31'd0, ihit}, 32'd1);
    check("t5 0x300 data", imemload, 32'hD000_0300);
    check("t5 miss_cnt",   {16'd0, miss_cnt}, 32'd5);

    // 6: asynchronous reset in the middle of a fill
    @(negedge CLK);
    imemaddr = 32'h500;
    iwait    = 1'b1;
    #1;
    check("t6 idle ihit", {31'd0, ihit}, 32'd0);
    @(negedge CLK); #1;
    check("t6 fill iREN", {31'd0, iREN}, 32'd1);
    check("t6 fill cnt",  {16'd0, miss_cnt}, 32'd6);
    #2;
    nRST = 1'b0;
    #1;
    check("t6 rst iREN",  {31'd0, iREN}, 32'd0);
    check("t6 rst iaddr", iaddr, 32'd0);
    check("t6 rst cnt",   {16'd0, miss_cnt}, 32'd0);
    @(negedge CLK);
    nRST     = 1'b1;
    iwait    = 1'b0;
    imemaddr = 32'h100;
    #1;
    check("t6 0x100 misses", {31'd0, ihit}, 32'd0);
    wait_hit("t6 0x100");
    check("t6 0x100 data", imemload, 32'h0000_00A0);
    check("t6 final cnt",  {16'd0, miss_cnt}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/icache_sa.md
Name: icache_sa

Overview:
- Parametrised set-associative, multi-word-block successor to the direct-mapped instruction cache.
- Sits between fetch (fetch_if side) and the memory arbiter (arbiter_caches_if side).
- Serves hits combinationally.
- On a miss, fills a whole block word-by-word through the arbiter, using round-robin replacement per set.
- Adds a flush and a miss counter.

Parameters:
- WORD_W, 32, word/address width.
- SETS, 8, number of sets; power of 2, >=2.
- WAYS, 2, associativity; power of 2, 1..4.
- BLK_WORDS, 2, words per block; power of 2, 1..4.
- CNT_W, 16, miss counter width.
- Derived: IDX_W=log2(SETS), WOFF_W=log2(BLK_WORDS) (0 when 1), TAG_W=WORD_W-2-WOFF_W-IDX_W.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset
- imemREN  in  1  fetch read request
- imemaddr  in  WORD_W  fetch byte address; bits[1:0] ignored
- ihit  out  1  imemload valid this cycle
- imemload  out  WORD_W  fetched instruction
- flush  in  1  invalidate all lines
- iREN  out  1  arbiter read request
- iaddr  out  WORD_W  arbiter word address
- iwait  in  1  arbiter busy; data valid when iREN && !iwait
- iload  in  WORD_W  arbiter read data
- miss_cnt  out  CNT_W  number of misses since reset

Reset and clock: reset nRST, asynchronous, active-low; clock CLK.

Behaviour:
- Address split: [1:0] byte, [WOFF_W+1:2] word offset, next IDX_W bits index, top TAG_W bits tag.
- Storage per set/way: valid, tag, BLK_WORDS data words. Per set: rr pointer (log2(WAYS) bits, 0 when WAYS=1).
- Reset: all valid=0, rr=0, state=IDLE, fill counter=0, miss_cnt=0; outputs ihit=0, imemload=0, iREN=0, iaddr=0.
- Hit: imemREN && any way valid with matching tag in the indexed set -> ihit=1 and imemload=word[offset] in the same cycle (0-cycle latency). No state change. Only one way may match; tags are never duplicated within a set.
- ihit=0 whenever imemREN=0; imemload=0 when ihit=0.
- FSM states:
  - IDLE: on imemREN && !hit && !flush -> latch tag, index, block base address and victim=rr[idx]; miss_cnt+=1 (wraps); fill counter=0; go FILL.
  - FILL: iREN=1, iaddr = block base + 4*counter. Each cycle with !iwait: store iload into a line buffer at counter, counter+=1. When the last word is accepted -> go WRITE.
  - WRITE (1 cycle): write buffer, latched tag and valid=1 into [idx][victim]; rr[idx]=victim+1 mod WAYS; go IDLE. iREN=0 in this state.
- ihit is never asserted in FILL or WRITE, even for other addresses. The cache is blocking.
- The next fetch of the filled address hits in the cycle after WRITE. Miss-to-hit latency = BLK_WORDS accepted beats + 2 cycles.
- imemaddr or imemREN changing during FILL: the fill still completes for the latched block. Fetch re-looks-up in IDLE.
- Victim choice: invalid ways are not preferred; rr alone selects the victim. rr advances only on fill.
- flush:
  - In IDLE or WRITE: all valid=0 and rr=0 next cycle; a WRITE coinciding with flush is discarded; state goes IDLE.
  - In FILL: abort; iREN drops next cycle; buffer is discarded; state goes IDLE.
  - ihit=0 in the flush cycle.
- A flush cycle never counts as a miss.
- Reset mid-fill: everything returns to reset values immediately; arbiter sees iREN drop asynchronously.

Decomposition:
- Shared cpu_types_pkg gets the icache_sa frame typedef (valid, tag, data array) built from the parameters.
- It also gets the FSM enum {IDLE, FILL, WRITE} and the address-field struct.
- One sub-module, icache_sa_lookup: combinational tag compare across WAYS that returns hit and way index.

Test Plan:
1. Reset then imemREN=1, addr=0x100, iwait=0, iload=0xA0,0xA1:
   - iREN for 2 cycles with iaddr 0x100 then 0x104.
   - WRITE, then ihit=1 with imemload=0xA0; addr 0x104 -> 0xA1; miss_cnt=1.
2. Conflict, default params, set stride 64 B: fill 0x000, then 0x040, then 0x080.
   - 0x080 evicts the way of 0x000 (rr): 0x000 misses again, 0x040 still hits; miss_cnt=4 after the re-fetch.
3. iwait held high for 5 cycles on each beat of a fill:
   - iaddr stays stable, no words stored during iwait, ihit stays 0 throughout.
   - Completes with correct data.
4. flush asserted on the 2nd FILL cycle of a miss to 0x200:
   - iREN drops, state IDLE, then 0x200 misses again.
   - Previously cached 0x100 also misses.
5. imemaddr switches from 0x300 to 0x100 (cached) during a 0x300 fill:
   - No ihit until after WRITE; then 0x100 hits, and later 0x300 hits without a new miss.
6. nRST asserted mid-FILL:
   - iREN=0, miss_cnt=0 immediately.
   - After release, the previously hit address 0x100 misses.
